scara_step_gen: RTL
===================

// Module: scara_step_gen
// PURPOSE
//  Dual-axis step/direction pulse generator sitting directly downstream of scara_controller.
//  Consumes absolute joint targets th1_steps/th2_steps (signed 14-bit step counts) and drives
//  step/dir lines of the two joint stepper drivers. Tracks the current joint positions and
//  signals completion so the controller can issue the next move.
// PARAMETERS
//  STEP_PERIOD  50000  clk cycles from one step rising edge to the next (1 kHz at 50 MHz)
//  PULSE_W      100    clk cycles step is held high; 1 <= PULSE_W < STEP_PERIOD
//  DIR_SETUP    50     clk cycles dir is stable before the first step rising edge; >= 1
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high
//  th1_steps  in   14  signed absolute target, joint 1 (sampled on accepted start)
//  th2_steps  in   14  signed absolute target, joint 2
//  start      in   1   request move; accepted only when busy==0
//  abort      in   1   stop motion at the next step boundary
//  step1      out  1   joint 1 step pulse
//  dir1       out  1   joint 1 direction, 1 = positive
//  step2      out  1   joint 2 step pulse
//  dir2       out  1   joint 2 direction, 1 = positive
//  th1_pos    out  14  signed current position, joint 1
//  th2_pos    out  14  signed current position, joint 2
//  busy       out  1   move in progress
//  done       out  1   one-cycle pulse when a move finishes or an abort completes
// BEHAVIOUR
//  - Reset: all outputs 0; positions 0; both axes IDLE. Reset mid-move wins immediately
//    (step low the next cycle; position counts are discarded).
//  - Accept: start && !busy in cycle N latches both targets. busy=1 from N+1.
//    start while busy is ignored; the targets are not re-sampled.
//  - Per axis, delta = target - pos, computed sign-extended to 15 bits (no overflow).
//    dir = (delta > 0). Step count = |delta|.
//  - Axis FSM: IDLE -> SETUP -> HIGH -> LOW -> (HIGH | IDLE).
//    * delta==0: the axis stays IDLE and never toggles dir or step.
//    * SETUP: dir is driven from N+1 and held for DIR_SETUP cycles. step first rises at N+1+DIR_SETUP.
//    * HIGH: lasts PULSE_W cycles. pos +/-1 in the cycle step rises.
//    * LOW: lasts STEP_PERIOD-PULSE_W cycles. Afterwards go to HIGH if steps remain,
//      else to IDLE.
//  - The axes run concurrently and independently (not interpolated).
//  - dir changes only in IDLE->SETUP. dir is held between moves.
//  - Completion: in the first cycle both axes are IDLE after an accepted start,
//    done=1 and busy=0 in that same cycle. A zero/zero move gives done at N+2.
//  - abort while busy:
//    * an axis in SETUP or LOW goes IDLE next cycle;
//    * an axis in HIGH completes its PULSE_W, then goes IDLE (no truncated pulses);
//    * pos reflects the pulses actually emitted;
//    * done fires when both axes are IDLE.
//  - abort while idle has no effect. abort and start in the same idle cycle: start is ignored.
//  - Counters are sized $clog2(STEP_PERIOD+1) and $clog2(DIR_SETUP+1). The step counter is 15 bits.
// STRUCTURE
//  - scara_pkg:
//    * POS_W=14;
//    * typedef enum logic [1:0] {AX_IDLE, AX_SETUP, AX_HIGH, AX_LOW} axis_state_t;
//    * the controller's unit_state/scara_state enums move here too.
//  - Sub-module scara_axis_stepper, instantiated twice:
//    * inputs: load, target, abort;
//    * outputs: step, dir, pos, idle.
//  - The top level holds only the accept/busy/done logic.
// TESTING (bench params STEP_PERIOD=4, PULSE_W=2, DIR_SETUP=2)
//  1 Reset: hold reset 3 cycles -> all outputs 0, th1_pos=th2_pos=0.
//  2 th1=+3, th2=-2, start at cycle 0:
//    - dir1=1, dir2=0 at cycle 1;
//    - step1 high at cycles 3-4, 7-8, 11-12; step2 high at 3-4 and 7-8;
//    - done at cycle 15; pos = +3 / -2.
//  3 Zero move, targets equal to current pos -> busy at cycle 1, done at cycle 2, no step edges.
//  4 start pulsed at cycle 5 during test-2's move, with new targets -> ignored;
//    final pos is unchanged from test 2.
//  5 th1=+10; abort at cycle 8, while step1 is high -> the pulse ends at cycle 8;
//    done at cycle 9; th1_pos=+2.
//  6 Reset at cycle 6 of a +10 move -> step1=0 and pos=0 at cycle 7; a new start is accepted at cycle 8.

Source files
------------

// File: rtl/scara_pkg.sv
// Shared types and constants for the SCARA arm control path.
// Contents:
//   POS_W          width of joint step counts (signed)
//   DELTA_W        width of a target-minus-position difference (one extra bit, cannot overflow)
//   axis_state_t   per-axis step generator states
//   unit_state_t   scara_controller per-unit states
//   scara_state_t  scara_controller top-level states
//   abs_delta()    magnitude of a signed difference
package scara_pkg;

    localparam int POS_W   = 14;
    localparam int DELTA_W = POS_W + 1;

    typedef enum logic [1:0] {AX_IDLE, AX_SETUP, AX_HIGH, AX_LOW} axis_state_t;

    // Controller-side states, kept here so both blocks share one definition.
    typedef enum logic [1:0] {UNIT_IDLE, UNIT_CALC, UNIT_DONE} unit_state_t;
    typedef enum logic [1:0] {SC_IDLE, SC_SOLVE, SC_ISSUE, SC_WAIT} scara_state_t;

    function automatic logic [DELTA_W-1:0] abs_delta(input logic signed [DELTA_W-1:0] d);
        return d[DELTA_W-1] ? -d : d;
    endfunction

endpackage

// File: rtl/scara_axis_stepper.sv
// Single-joint step/direction generator.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   load        latch target and begin a move (ignored unless idle)
//   target      signed absolute target in steps
//   abort       stop at the next step boundary; a running pulse is completed
//   step        step pulse, high for PULSE_W cycles per step
//   dir         direction, 1 = positive; held between moves
//   pos         signed current position, updated as each step rises
//   idle        axis is in AX_IDLE
module scara_axis_stepper
    import scara_pkg::*;
#(
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_W     = 100,
    parameter int DIR_SETUP   = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [POS_W-1:0] target,
    input  logic                    abort,
    output logic                    step,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
    output logic                    idle
);

    localparam int PER_W = $clog2(STEP_PERIOD + 1);
    localparam int SET_W = $clog2(DIR_SETUP + 1);

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [PER_W-1:0] HIGH_LAST  = PER_W'(PULSE_W - 1);
    localparam logic [PER_W-1:0] LOW_LAST   = PER_W'(STEP_PERIOD - PULSE_W - 1);
    localparam logic [SET_W-1:0] SETUP_LAST = SET_W'(DIR_SETUP - 1);

    axis_state_t               state, state_next;
    logic        [PER_W-1:0]   per_cnt;
    logic        [SET_W-1:0]   set_cnt;
    logic        [DELTA_W-1:0] remaining;
    logic                      abort_held;
    logic signed [DELTA_W-1:0] delta;
    logic                      enter_high;

    // Sign-extend both operands so the difference of two 14-bit values cannot wrap.
    assign delta      = {target[POS_W-1], target} - {pos[POS_W-1], pos};
    assign enter_high = (state_next == AX_HIGH) && (state != AX_HIGH);
    assign step       = (state == AX_HIGH);
    assign idle       = (state == AX_IDLE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            AX_IDLE:  if (load && delta != '0) state_next = AX_SETUP;
            AX_SETUP: begin
                if (abort)              state_next = AX_IDLE;
                else if (set_cnt == '0) state_next = AX_HIGH;
            end
            // A pulse is never truncated: an abort seen during HIGH takes effect at its end.
            AX_HIGH:  if (per_cnt == '0) state_next = (abort || abort_held) ? AX_IDLE : AX_LOW;
            AX_LOW: begin
                if (abort)              state_next = AX_IDLE;
                else if (per_cnt == '0) state_next = (remaining != '0) ? AX_HIGH : AX_IDLE;
            end
            default:                    state_next = AX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= AX_IDLE;
            dir        <= 1'b0;
            pos        <= '0;
            per_cnt    <= '0;
            set_cnt    <= '0;
            remaining  <= '0;
            abort_held <= 1'b0;
        end else begin
            state <= state_next;

            if (state == AX_IDLE && state_next == AX_SETUP) begin
                dir       <= ~delta[DELTA_W-1];
                remaining <= abs_delta(delta);
                set_cnt   <= SETUP_LAST;
            end else if (state == AX_SETUP) begin
                set_cnt <= set_cnt - SET_W'(1);
            end

            if (enter_high) begin
                pos       <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
                remaining <= remaining - DELTA_W'(1);
                per_cnt   <= HIGH_LAST;
            end else if (state == AX_HIGH && state_next == AX_LOW) begin
                per_cnt <= LOW_LAST;
            end else if ((state == AX_HIGH || state == AX_LOW) && per_cnt != '0) begin
                per_cnt <= per_cnt - PER_W'(1);
            end

            abort_held <= (state == AX_HIGH) && (state_next == AX_HIGH) && (abort || abort_held);
        end
    end

endmodule

// File: rtl/scara_step_gen.sv
// Dual-axis step/direction generator driven by scara_controller.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   th1_steps, th2_steps signed absolute joint targets, sampled on an accepted start
//   start                request a move; accepted only while busy is low and abort is low
//   abort                stop both axes at their next step boundary (only while busy)
//   step1/dir1           joint 1 step pulse and direction (1 = positive)
//   step2/dir2           joint 2 step pulse and direction
//   th1_pos, th2_pos     signed current joint positions
//   busy                 move in progress
//   done                 one-cycle pulse when a move or abort completes
module scara_step_gen
    import scara_pkg::*;
#(
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_W     = 100,
    parameter int DIR_SETUP   = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [POS_W-1:0] th1_steps,
    input  logic signed [POS_W-1:0] th2_steps,
    input  logic                    start,
    input  logic                    abort,
    output logic                    step1,
    output logic                    dir1,
    output logic                    step2,
    output logic                    dir2,
    output logic signed [POS_W-1:0] th1_pos,
    output logic signed [POS_W-1:0] th2_pos,
    output logic                    busy,
    output logic                    done
);

    logic busy_q;
    logic first_q;
    logic idle1, idle2;
    logic accept;
    logic axis_abort;

    // Both axes are still idle in the cycle right after a zero-length accept, so
    // completion is held off for that first cycle to keep busy visible for one cycle.
    assign done       = busy_q && !first_q && idle1 && idle2;
    assign busy       = busy_q && !done;
    assign accept     = start && !busy && !abort;
    assign axis_abort = abort && busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            first_q <= accept;
            if (accept)    busy_q <= 1'b1;
            else if (done) busy_q <= 1'b0;
        end
    end

    scara_axis_stepper #(
        .STEP_PERIOD (STEP_PERIOD),
        .PULSE_W     (PULSE_W),
        .DIR_SETUP   (DIR_SETUP)
    ) u_axis1 (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .target (th1_steps),
        .abort  (axis_abort),
        .step   (step1),
        .dir    (dir1),
        .pos    (th1_pos),
        .idle   (idle1)
    );

    scara_axis_stepper #(
        .STEP_PERIOD (STEP_PERIOD),
        .PULSE_W     (PULSE_W),
        .DIR_SETUP   (DIR_SETUP)
    ) u_axis2 (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .target (th2_steps),
        .abort  (axis_abort),
        .step   (step2),
        .dir    (dir2),
        .pos    (th2_pos),
        .idle   (idle2)
    );

endmodule
